// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Covers the EX->MEM / MEM->WB bus layouts, load-op encodings and FSM state codes.
package mem_stage_pkg;

    localparam int PASS_WD         = 160;
    localparam int ES_TO_MS_BUS_WD = PASS_WD + 80;
    localparam int MS_TO_WS_BUS_WD = PASS_WD + 71;
    // ertn marker inside the pass-through sideband
    localparam int PASS_ERTN_BIT   = 0;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_H    = 3'd2,
        LD_W    = 3'd3,
        LD_BU   = 3'd4,
        LD_HU   = 3'd5
    } load_op_e;

    typedef enum logic [1:0] {
        MS_IDLE    = 2'd0,
        MS_WAIT    = 2'd1,
        MS_DISCARD = 2'd2
    } ms_state_e;

    typedef struct packed {
        logic [PASS_WD-1:0] pass;
        logic               ex;
        logic               mem_req;
        logic [2:0]         load_op;
        logic               gr_we;
        logic [4:0]         dest;
        logic [31:0]        result;
        logic [31:0]        pc;
    } ms_pl_t;

    // The named fields fill PASS_WD+75 bits; the top 5 bits of the bus carry nothing.
    typedef struct packed {
        logic [4:0] rsvd;
        ms_pl_t     pl;
    } es_to_ms_t;

    typedef struct packed {
        logic [PASS_WD-1:0] pass;
        logic               ex;
        logic               gr_we;
        logic [4:0]         dest;
        logic [31:0]        final_result;
        logic [31:0]        pc;
    } ms_to_ws_t;

    function automatic logic ld_is_load(logic [2:0] op);
        return op != LD_NONE;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Handshake, payload, data-SRAM response and forwarding signals around the MEM stage.
// master = surrounding pipeline (EX, WB, SRAM, decode); slave = the MEM stage itself.
interface mem_stage_if
    import mem_stage_pkg::*;
();
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_allowin;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic                       ws_flush_pipe;
    logic                       ms_fwd_valid;
    logic [4:0]                 ms_fwd_dest;
    logic [31:0]                ms_fwd_data;
    logic                       ms_fwd_blocking;
    logic                       ms_ex_flag;

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin,
               data_sram_data_ok, data_sram_rdata, ws_flush_pipe,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_blocking, ms_ex_flag
    );

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
               data_sram_data_ok, data_sram_rdata, ws_flush_pipe,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_blocking, ms_ex_flag
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/halfword out of a 32-bit load word and extends it.
// Purely combinational; offsets are trusted (misalignment is excepted upstream).
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  load_op,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
        case (load_op)
            LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   data = {24'h0, byte_sel};
            LD_H:    data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   data = {16'h0, half_sel};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data-SRAM beat, aligns load
// data and hands off to WB; drains the orphaned beat of a flushed access before accepting more.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.slave bus_if
);
    es_to_ms_t   es_in;
    ms_pl_t      pl_q, pl_d;
    ms_to_ws_t   ws_out;
    ms_state_e   state_q, state_d;
    logic        ms_valid_q, ms_valid_d;
    logic        rbuf_v_q, rbuf_v_d;
    logic [31:0] rbuf_q, rbuf_d;

    logic        flush, data_ok, wait_hit;
    logic        ms_ready_go, ms_allowin, ms_to_ws_valid;
    logic        leave, capture;
    logic [31:0] word, ld_data, final_result;
    logic        unused_rsvd;

    assign es_in       = es_to_ms_t'(bus_if.es_to_ms_bus);
    assign unused_rsvd = ^es_in.rsvd;
    assign flush       = bus_if.ws_flush_pipe;
    assign data_ok     = bus_if.data_sram_data_ok;

    // A beat arriving while waiting completes the access in that same cycle.
    assign wait_hit    = (state_q == MS_WAIT) && data_ok;
    assign ms_ready_go = ~ms_valid_q | pl_q.ex | ~pl_q.mem_req | rbuf_v_q | wait_hit;
    // While draining a stale beat, nothing new may enter or it would be paired with that beat.
    assign ms_allowin  = (~ms_valid_q | (ms_ready_go & bus_if.ws_allowin))
                         & (state_q != MS_DISCARD);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~flush;
    assign leave          = ms_to_ws_valid & bus_if.ws_allowin;
    assign capture        = bus_if.es_to_ms_valid & ms_allowin & ~flush;

    assign word = rbuf_v_q ? rbuf_q : bus_if.data_sram_rdata;

    mem_stage_load_align u_align (
        .word    (word),
        .off     (pl_q.result[1:0]),
        .load_op (pl_q.load_op),
        .data    (ld_data)
    );

    assign final_result = (pl_q.load_op == LD_NONE) ? pl_q.result : ld_data;

    always_comb begin
        ms_valid_d = ms_valid_q;
        pl_d       = pl_q;
        rbuf_d     = rbuf_q;
        rbuf_v_d   = rbuf_v_q;
        state_d    = state_q;

        if (flush)           ms_valid_d = 1'b0;
        else if (ms_allowin) ms_valid_d = bus_if.es_to_ms_valid;

        if (capture)  pl_d   = es_in.pl;
        if (wait_hit) rbuf_d = bus_if.data_sram_rdata;

        // Leaving wins over latching so the buffered word never leaks into the next op.
        if (flush || leave) rbuf_v_d = 1'b0;
        else if (wait_hit)  rbuf_v_d = 1'b1;

        if (state_q == MS_DISCARD) begin
            if (data_ok) state_d = MS_IDLE;
        end else if (flush) begin
            state_d = wait_hit ? MS_IDLE : ((state_q == MS_WAIT) ? MS_DISCARD : MS_IDLE);
        end else if (capture) begin
            state_d = (es_in.pl.mem_req && !es_in.pl.ex) ? MS_WAIT : MS_IDLE;
        end else if (wait_hit) begin
            state_d = MS_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q <= 1'b0;
            pl_q       <= '0;
            rbuf_q     <= '0;
            rbuf_v_q   <= 1'b0;
            state_q    <= MS_IDLE;
        end else begin
            ms_valid_q <= ms_valid_d;
            pl_q       <= pl_d;
            rbuf_q     <= rbuf_d;
            rbuf_v_q   <= rbuf_v_d;
            state_q    <= state_d;
        end
    end

    assign ws_out = '{
        pass:         pl_q.pass,
        ex:           pl_q.ex,
        gr_we:        pl_q.gr_we,
        dest:         pl_q.dest,
        final_result: final_result,
        pc:           pl_q.pc
    };

    assign bus_if.ms_allowin      = ms_allowin;
    assign bus_if.ms_to_ws_valid  = ms_to_ws_valid;
    assign bus_if.ms_to_ws_bus    = ws_out;
    assign bus_if.ms_fwd_valid    = ms_valid_q & pl_q.gr_we & ~pl_q.ex;
    assign bus_if.ms_fwd_dest     = pl_q.dest;
    assign bus_if.ms_fwd_data     = final_result;
    assign bus_if.ms_fwd_blocking = ms_valid_q & pl_q.mem_req & ld_is_load(pl_q.load_op)
                                    & ~pl_q.ex & ~ms_ready_go;
    assign bus_if.ms_ex_flag      = ms_valid_q & (pl_q.ex | pl_q.pass[PASS_ERTN_BIT]);
endmodule

// File: tb/tb_mem_stage.sv
// Random + directed bench for mem_stage against a transaction-level model of the stage
// (one held instruction, an arrived-data flag, an orphan flag) and a queued SRAM responder.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_stage_if u_if ();

    mem_stage u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus_if (u_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic        m_valid, m_have, m_orphan;
    es_to_ms_t   m_inst;
    logic [31:0] m_word;
    int unsigned pend[$];
    int unsigned cyc;
    int          dly_fix = -1;
    logic        use_rd  = 1'b0;
    logic [31:0] fix_rd  = '0;

    // last sampled DUT values, for directed constant checks
    logic        obs_ov, obs_blk, obs_alw, obs_fwdv, obs_exf, obs_exb;
    logic [31:0] obs_final, obs_fwdd;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_final(logic [2:0] op, logic [31:0] res, logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * res[1:0])) & 32'hFF;
        h = res[1] ? (w >> 16) : (w & 32'hFFFF);
        case (op)
            3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd2:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            3'd3:    return w;
            default: return res;
        endcase
    endfunction

    function automatic es_to_ms_t mk(logic ex, logic mr, logic [2:0] op, logic gw,
                                     logic [4:0] d, logic [31:0] res);
        es_to_ms_t e;
        e = '0;
        for (int i = 0; i < PASS_WD / 32; i++) e.pl.pass[i*32 +: 32] = $urandom();
        e.pl.pass[PASS_ERTN_BIT] = 1'b0;
        e.rsvd       = 5'($urandom());
        e.pl.ex      = ex;
        e.pl.mem_req = mr;
        e.pl.load_op = op;
        e.pl.gr_we   = gw;
        e.pl.dest    = d;
        e.pl.result  = res;
        e.pl.pc      = $urandom();
        return e;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_have   = 1'b0;
        m_orphan = 1'b0;
        m_inst   = '0;
        m_word   = '0;
        pend.delete();
    endtask

    // One clock cycle: drive inputs at the falling edge, compare, then advance the model.
    task automatic step(input logic ev, input es_to_ms_t eb, input logic wa, input logic fl);
        logic dok, need, rdy, alw, ov, blk, lv;
        logic [31:0] rd, w, fin;
        logic [MS_TO_WS_BUS_WD-1:0] exp_bus;
        @(negedge clk);
        dok = (pend.size() > 0) && (pend[0] <= cyc);
        rd  = use_rd ? fix_rd : $urandom();
        u_if.es_to_ms_valid    = ev;
        u_if.es_to_ms_bus      = eb;
        u_if.ws_allowin        = wa;
        u_if.ws_flush_pipe     = fl;
        u_if.data_sram_data_ok = dok;
        u_if.data_sram_rdata   = rd;
        #1;
        need = m_valid && m_inst.pl.mem_req && !m_inst.pl.ex && !m_have;
        rdy  = !need || dok;
        alw  = !m_orphan && (!m_valid || (rdy && wa));
        ov   = m_valid && rdy && !fl;
        blk  = m_valid && m_inst.pl.mem_req && (m_inst.pl.load_op != 3'd0) && !m_inst.pl.ex && !rdy;
        w    = m_have ? m_word : rd;
        fin  = ref_final(m_inst.pl.load_op, m_inst.pl.result, w);
        exp_bus = {m_inst.pl.pass, m_inst.pl.ex, m_inst.pl.gr_we, m_inst.pl.dest, fin, m_inst.pl.pc};

        chk("allowin",  256'(u_if.ms_allowin),      256'(alw));
        chk("out_vld",  256'(u_if.ms_to_ws_valid),  256'(ov));
        chk("out_bus",  256'(u_if.ms_to_ws_bus),    256'(exp_bus));
        chk("fwd_vld",  256'(u_if.ms_fwd_valid),    256'(m_valid && m_inst.pl.gr_we && !m_inst.pl.ex));
        chk("fwd_dest", 256'(u_if.ms_fwd_dest),     256'(m_inst.pl.dest));
        chk("fwd_data", 256'(u_if.ms_fwd_data),     256'(fin));
        chk("blocking", 256'(u_if.ms_fwd_blocking), 256'(blk));
        chk("ex_flag",  256'(u_if.ms_ex_flag),
            256'(m_valid && (m_inst.pl.ex || m_inst.pl.pass[PASS_ERTN_BIT])));

        obs_ov    = u_if.ms_to_ws_valid;
        obs_blk   = u_if.ms_fwd_blocking;
        obs_alw   = u_if.ms_allowin;
        obs_fwdv  = u_if.ms_fwd_valid;
        obs_exf   = u_if.ms_ex_flag;
        obs_exb   = u_if.ms_to_ws_bus[70];
        obs_final = u_if.ms_to_ws_bus[63:32];
        obs_fwdd  = u_if.ms_fwd_data;

        lv = ov && wa;
        if (dok) void'(pend.pop_front());
        if (m_orphan && dok) m_orphan = 1'b0;
        if (need && dok) begin
            m_have = 1'b1;
            m_word = rd;
        end
        if (lv) m_have = 1'b0;
        if (fl) begin
            if (need && !dok) m_orphan = 1'b1;
            m_valid = 1'b0;
            m_have  = 1'b0;
        end else if (alw) begin
            m_valid = ev;
            if (ev) begin
                m_inst = eb;
                m_have = 1'b0;
                if (eb.pl.mem_req && !eb.pl.ex)
                    pend.push_back(cyc + 1 + ((dly_fix >= 0) ? dly_fix : $urandom_range(0, 3)));
            end
        end
        cyc++;
        use_rd = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        es_to_ms_t idle, nx;
        logic [31:0] r [4];
        idle = '0;
        cyc  = 0;
        model_reset();
        resetn = 1'b0;
        u_if.es_to_ms_valid    = 1'b0;
        u_if.es_to_ms_bus      = '0;
        u_if.ws_allowin        = 1'b0;
        u_if.ws_flush_pipe     = 1'b0;
        u_if.data_sram_data_ok = 1'b0;
        u_if.data_sram_rdata   = '0;
        #12;
        chk("rst_allowin", 256'(u_if.ms_allowin),      256'(1));
        chk("rst_out_vld", 256'(u_if.ms_to_ws_valid),  256'(0));
        chk("rst_bus",     256'(u_if.ms_to_ws_bus),    256'(0));
        chk("rst_fwd",     256'({u_if.ms_fwd_valid, u_if.ms_fwd_dest, u_if.ms_fwd_data}), 256'(0));
        chk("rst_blk_ex",  256'({u_if.ms_fwd_blocking, u_if.ms_ex_flag}), 256'(0));
        @(negedge clk);
        resetn = 1'b1;

        // ld.b, beat two cycles after capture
        dly_fix = 2;
        step(1'b1, mk(1'b0, 1'b1, LD_B, 1'b1, 5'd5, 32'h1003), 1'b1, 1'b0);
        dly_fix = -1;
        step(1'b0, idle, 1'b1, 1'b0); chk("ldb_blk0", 256'(obs_blk), 256'(1));
        step(1'b0, idle, 1'b1, 1'b0); chk("ldb_blk1", 256'(obs_blk), 256'(1));
        use_rd = 1'b1; fix_rd = 32'h80FF_1234;
        step(1'b0, idle, 1'b1, 1'b0);
        chk("ldb_ov",   256'(obs_ov),    256'(1));
        chk("ldb_data", 256'(obs_final), 256'(32'hFFFF_FF80));

        // ld.hu, beat the cycle right after capture
        dly_fix = 0;
        step(1'b1, mk(1'b0, 1'b1, LD_HU, 1'b1, 5'd6, 32'h2002), 1'b1, 1'b0);
        dly_fix = -1;
        use_rd = 1'b1; fix_rd = 32'h80FF_1234;
        step(1'b0, idle, 1'b1, 1'b0);
        chk("ldhu_ov",   256'(obs_ov),    256'(1));
        chk("ldhu_blk",  256'(obs_blk),   256'(0));
        chk("ldhu_data", 256'(obs_final), 256'(32'h0000_80FF));

        // ld.w held by WB backpressure, served from the buffered word
        dly_fix = 0;
        step(1'b1, mk(1'b0, 1'b1, LD_W, 1'b1, 5'd7, 32'h3000), 1'b1, 1'b0);
        dly_fix = -1;
        use_rd = 1'b1; fix_rd = 32'hDEAD_BEEF;
        step(1'b0, idle, 1'b0, 1'b0);
        chk("ldw_bp_ov", 256'(obs_ov), 256'(1));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, idle, 1'b0, 1'b0);
            chk("ldw_bp_hold", 256'(obs_final), 256'(32'hDEAD_BEEF));
        end
        step(1'b0, idle, 1'b1, 1'b0);
        chk("ldw_bp_rel", 256'(obs_final), 256'(32'hDEAD_BEEF));
        step(1'b0, idle, 1'b1, 1'b0);
        chk("ldw_bp_once", 256'(obs_ov), 256'(0));

        // flush while waiting: stale beat must be drained, not handed to the next load
        dly_fix = 3;
        step(1'b1, mk(1'b0, 1'b1, LD_W, 1'b1, 5'd8, 32'h100), 1'b1, 1'b0);
        dly_fix = -1;
        step(1'b0, idle, 1'b1, 1'b1);
        nx = mk(1'b0, 1'b1, LD_W, 1'b1, 5'd9, 32'h200);
        step(1'b1, nx, 1'b1, 1'b0);
        chk("fl_ov0",  256'(obs_ov),  256'(0));
        chk("fl_alw0", 256'(obs_alw), 256'(0));
        step(1'b1, nx, 1'b1, 1'b0);
        chk("fl_alw1", 256'(obs_alw), 256'(0));
        use_rd = 1'b1; fix_rd = 32'hBAD0_BAD0;
        step(1'b1, nx, 1'b1, 1'b0);
        chk("fl_alw2", 256'(obs_alw), 256'(0));
        dly_fix = 0;
        step(1'b1, nx, 1'b1, 1'b0);
        chk("fl_alw_back", 256'(obs_alw), 256'(1));
        dly_fix = -1;
        use_rd = 1'b1; fix_rd = 32'h1234_5678;
        step(1'b0, idle, 1'b1, 1'b0);
        chk("fl_next_ov",   256'(obs_ov),    256'(1));
        chk("fl_next_data", 256'(obs_final), 256'(32'h1234_5678));

        // excepted memory op passes straight through
        step(1'b1, mk(1'b1, 1'b1, LD_W, 1'b1, 5'd10, 32'h400), 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);
        chk("ex_ov",   256'(obs_ov),   256'(1));
        chk("ex_flag", 256'(obs_exf),  256'(1));
        chk("ex_fwdv", 256'(obs_fwdv), 256'(0));
        chk("ex_bit",  256'(obs_exb),  256'(1));

        // back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            r[i] = 32'hA000_0000 + 32'($urandom_range(0, 4095));
            step(1'b1, mk(1'b0, 1'b0, LD_NONE, 1'b1, 5'(i + 1), r[i]), 1'b1, 1'b0);
            chk("alu_alw", 256'(obs_alw), 256'(1));
            if (i > 0) begin
                chk("alu_ov",  256'(obs_ov),   256'(1));
                chk("alu_fwd", 256'(obs_fwdd), 256'(r[i-1]));
            end
        end
        step(1'b0, idle, 1'b1, 1'b0);
        chk("alu_last", 256'(obs_fwdd), 256'(r[3]));

        // reset in the middle of a wait
        dly_fix = 3;
        step(1'b1, mk(1'b0, 1'b1, LD_W, 1'b1, 5'd11, 32'h500), 1'b1, 1'b0);
        dly_fix = -1;
        step(1'b0, idle, 1'b1, 1'b0);
        chk("mid_blk", 256'(obs_blk), 256'(1));
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_alw", 256'(u_if.ms_allowin),      256'(1));
        chk("mid_rst_ov",  256'(u_if.ms_to_ws_valid),  256'(0));
        chk("mid_rst_blk", 256'(u_if.ms_fwd_blocking), 256'(0));
        model_reset();
        @(negedge clk);
        resetn = 1'b1;

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            es_to_ms_t eb;
            eb = mk($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                    5'($urandom()), $urandom());
            eb.pl.pass[PASS_ERTN_BIT] = ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 9) < 7, eb, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
